// File: rtl/pipe_ctrl.sv
// Hazard/sequencing controller for the 5-stage rv64IM pipeline: multi-cycle div/rem stall,
// taken-branch flush, load-use stall. Optional perf counters under `PIPE_CTRL_PERF_CNT_EN.
module pipe_ctrl #(
    parameter int unsigned MD_LATENCY = 8,
    parameter int unsigned CNT_W      = 6
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [4:0]  id_rs1,
    input  logic [4:0]  id_rs2,
    input  logic        id_use_rs1,
    input  logic        id_use_rs2,
    input  logic        ex_load,
    input  logic        ex_wen,
    input  logic [4:0]  ex_rd,
    input  logic        ex_md_op,
    input  logic        ex_branch_taken,
    output logic        stall_pc,
    output logic        stall_if_id,
    output logic        flush_if_id,
    output logic        stall_id_ex,
    output logic        flush_id_ex,
    output logic        ex_bubble,
`ifdef PIPE_CTRL_PERF_CNT_EN
    output logic [63:0] perf_stall_cycles,
    output logic [63:0] perf_flush_cycles,
    output logic [63:0] perf_md_ops,
`endif
    output logic        md_busy
);

    localparam logic [0:0] RUN     = 1'b0;
    localparam logic [0:0] MD_WAIT = 1'b1;

    localparam bit MD_EN = (MD_LATENCY > 1);
    localparam logic [CNT_W-1:0] CNT_INIT = MD_EN ? CNT_W'(MD_LATENCY - 2) : '0;

    logic [0:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             load_use;
    logic             md_enter;

    assign load_use = ex_load & ex_wen & (ex_rd != 5'd0) &
                      ((id_use_rs1 & (id_rs1 == ex_rd)) | (id_use_rs2 & (id_rs2 == ex_rd)));

    assign md_enter = !reset && (state_q == RUN) && MD_EN && ex_md_op;

    // Priority: multi-cycle EX op, then taken branch, then load-use; all outputs low in reset.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        stall_pc    = 1'b0;
        stall_if_id = 1'b0;
        flush_if_id = 1'b0;
        stall_id_ex = 1'b0;
        flush_id_ex = 1'b0;
        ex_bubble   = 1'b0;
        md_busy     = 1'b0;
        if (!reset) begin
            if (state_q == MD_WAIT) begin
                md_busy = 1'b1;
                if (cnt_q != '0) begin
                    stall_pc    = 1'b1;
                    stall_if_id = 1'b1;
                    stall_id_ex = 1'b1;
                    ex_bubble   = 1'b1;
                    cnt_d       = cnt_q - CNT_W'(1);
                end else begin
                    state_d = RUN;
                end
            end else if (md_enter) begin
                stall_pc    = 1'b1;
                stall_if_id = 1'b1;
                stall_id_ex = 1'b1;
                ex_bubble   = 1'b1;
                cnt_d       = CNT_INIT;
                state_d     = MD_WAIT;
            end else if (ex_branch_taken) begin
                flush_if_id = 1'b1;
                flush_id_ex = 1'b1;
            end else if (load_use) begin
                stall_pc    = 1'b1;
                stall_if_id = 1'b1;
                flush_id_ex = 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= RUN;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

`ifdef PIPE_CTRL_PERF_CNT_EN
    always_ff @(posedge clock) begin
        if (reset) begin
            perf_stall_cycles <= '0;
            perf_flush_cycles <= '0;
            perf_md_ops       <= '0;
        end else begin
            perf_stall_cycles <= perf_stall_cycles + 64'(stall_pc);
            perf_flush_cycles <= perf_flush_cycles + 64'(flush_if_id);
            perf_md_ops       <= perf_md_ops + 64'(md_enter);
        end
    end
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl: one DUT at MD_LATENCY=8, one at MD_LATENCY=4, shared stimulus.
module tb_pipe_ctrl;

    logic       clock;
    logic       reset;
    logic [4:0] id_rs1, id_rs2, ex_rd;
    logic       id_use_rs1, id_use_rs2, ex_load, ex_wen, ex_md_op, ex_branch_taken;

    logic s_pc8, s_ifid8, f_ifid8, s_idex8, f_idex8, bub8, busy8;
    logic s_pc4, s_ifid4, f_ifid4, s_idex4, f_idex4, bub4, busy4;
`ifdef PIPE_CTRL_PERF_CNT_EN
    logic [63:0] pst8, pfl8, pmd8, pst4, pfl4, pmd4;
`endif

    logic [6:0] obs8, obs4;
    assign obs8 = {s_pc8, s_ifid8, f_ifid8, s_idex8, f_idex8, bub8, busy8};
    assign obs4 = {s_pc4, s_ifid4, f_ifid4, s_idex4, f_idex4, bub4, busy4};

    // {stall_pc, stall_if_id, flush_if_id, stall_id_ex, flush_id_ex, ex_bubble, md_busy}
    localparam logic [6:0] IDLE  = 7'b0000000;
    localparam logic [6:0] ENTRY = 7'b1101010;
    localparam logic [6:0] WAIT  = 7'b1101011;
    localparam logic [6:0] REL   = 7'b0000001;
    localparam logic [6:0] LU    = 7'b1100100;
    localparam logic [6:0] BR    = 7'b0010100;

    int tests = 0;
    int fails = 0;

    pipe_ctrl #(.MD_LATENCY(8), .CNT_W(6)) u_dut8 (
        .clock(clock), .reset(reset), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .ex_load(ex_load),
        .ex_wen(ex_wen), .ex_rd(ex_rd), .ex_md_op(ex_md_op), .ex_branch_taken(ex_branch_taken),
        .stall_pc(s_pc8), .stall_if_id(s_ifid8), .flush_if_id(f_ifid8),
        .stall_id_ex(s_idex8), .flush_id_ex(f_idex8), .ex_bubble(bub8),
`ifdef PIPE_CTRL_PERF_CNT_EN
        .perf_stall_cycles(pst8), .perf_flush_cycles(pfl8), .perf_md_ops(pmd8),
`endif
        .md_busy(busy8)
    );

    pipe_ctrl #(.MD_LATENCY(4), .CNT_W(6)) u_dut4 (
        .clock(clock), .reset(reset), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .ex_load(ex_load),
        .ex_wen(ex_wen), .ex_rd(ex_rd), .ex_md_op(ex_md_op), .ex_branch_taken(ex_branch_taken),
        .stall_pc(s_pc4), .stall_if_id(s_ifid4), .flush_if_id(f_ifid4),
        .stall_id_ex(s_idex4), .flush_id_ex(f_idex4), .ex_bubble(bub4),
`ifdef PIPE_CTRL_PERF_CNT_EN
        .perf_stall_cycles(pst4), .perf_flush_cycles(pfl4), .perf_md_ops(pmd4),
`endif
        .md_busy(busy4)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic clear_inputs();
        id_rs1 = '0; id_rs2 = '0; ex_rd = '0;
        id_use_rs1 = 1'b0; id_use_rs2 = 1'b0; ex_load = 1'b0; ex_wen = 1'b0;
        ex_md_op = 1'b0; ex_branch_taken = 1'b0;
    endtask

    task automatic do_reset();
        clear_inputs();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        ex_md_op = 1'b1; ex_branch_taken = 1'b1;
        ex_load = 1'b1; ex_wen = 1'b1; ex_rd = 5'd5; id_use_rs2 = 1'b1; id_rs2 = 5'd5;
        for (int c = 0; c < 3; c++) begin
            #1;
            tests++;
            if (obs8 !== IDLE) begin
                fails++;
                $display("FAIL reset_out8 cyc%0d: got %b want %b", c, obs8, IDLE);
            end
            tests++;
            if (obs4 !== IDLE) begin
                fails++;
                $display("FAIL reset_out4 cyc%0d: got %b want %b", c, obs4, IDLE);
            end
            tick();
        end
        reset = 1'b0;
        clear_inputs();
        #1;
        tests++;
        if (obs8 !== IDLE) begin
            fails++;
            $display("FAIL reset_release_idle: got %b want %b", obs8, IDLE);
        end
`ifdef PIPE_CTRL_PERF_CNT_EN
        tests++;
        if ({pst8, pfl8, pmd8} !== 192'd0) begin
            fails++;
            $display("FAIL reset_perf: got %0d/%0d/%0d want 0/0/0", pst8, pfl8, pmd8);
        end
`endif
        ex_md_op = 1'b1;
        #1;
        tests++;
        if (obs8 !== ENTRY) begin
            fails++;
            $display("FAIL reset_state_run: got %b want %b", obs8, ENTRY);
        end
        do_reset();
    endtask

    task automatic test_md_single();
        do_reset();
        ex_md_op = 1'b1;
        for (int c = 0; c < 8; c++) begin
            logic [6:0] exp;
            // a taken branch mid-stall must be ignored
            ex_branch_taken = (c == 2 || c == 5);
            exp = (c == 0) ? ENTRY : (c < 7) ? WAIT : REL;
            #1;
            tests++;
            if (obs8 !== exp) begin
                fails++;
                $display("FAIL md_single t+%0d: got %b want %b", c, obs8, exp);
            end
            tick();
        end
        clear_inputs();
        #1;
        tests++;
        if (obs8 !== IDLE) begin
            fails++;
            $display("FAIL md_single_after: got %b want %b", obs8, IDLE);
        end
`ifdef PIPE_CTRL_PERF_CNT_EN
        tests++;
        if (pmd8 !== 64'd1 || pst8 !== 64'd7 || pfl8 !== 64'd0) begin
            fails++;
            $display("FAIL md_single_perf: got %0d/%0d/%0d want 7/0/1", pst8, pfl8, pmd8);
        end
`endif
    endtask

    task automatic test_back_to_back();
        int stalls;
        stalls = 0;
        do_reset();
        ex_md_op = 1'b1;
        for (int c = 0; c < 8; c++) begin
            logic [6:0] exp;
            exp = ((c % 4) == 0) ? ENTRY : ((c % 4) == 3) ? REL : WAIT;
            #1;
            tests++;
            if (obs4 !== exp) begin
                fails++;
                $display("FAIL b2b t+%0d: got %b want %b", c, obs4, exp);
            end
            if (s_pc4 === 1'b1) stalls++;
            tick();
        end
        clear_inputs();
        #1;
        tests++;
        if (stalls != 6) begin
            fails++;
            $display("FAIL b2b_stall_total: got %0d want 6", stalls);
        end
        tests++;
        if (obs4 !== IDLE) begin
            fails++;
            $display("FAIL b2b_after: got %b want %b", obs4, IDLE);
        end
`ifdef PIPE_CTRL_PERF_CNT_EN
        tests++;
        if (pmd4 !== 64'd2) begin
            fails++;
            $display("FAIL b2b_perf_md: got %0d want 2", pmd4);
        end
`endif
    endtask

    task automatic test_load_use();
        // {load, wen, rd, use1, rs1, use2, rs2, expected}
        logic [25:0] vec [8];
        vec[0] = {1'b1, 1'b1, 5'd5, 1'b0, 5'd0, 1'b1, 5'd5, LU};
        vec[1] = {1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd5, IDLE};
        vec[2] = {1'b1, 1'b1, 5'd0, 1'b0, 5'd0, 1'b1, 5'd5, IDLE};
        vec[3] = {1'b1, 1'b1, 5'd0, 1'b0, 5'd0, 1'b1, 5'd0, IDLE};
        vec[4] = {1'b1, 1'b1, 5'd7, 1'b0, 5'd7, 1'b0, 5'd7, IDLE};
        vec[5] = {1'b1, 1'b1, 5'd7, 1'b1, 5'd7, 1'b0, 5'd3, LU};
        vec[6] = {1'b1, 1'b0, 5'd7, 1'b1, 5'd7, 1'b0, 5'd3, IDLE};
        vec[7] = {1'b0, 1'b1, 5'd31, 1'b1, 5'd31, 1'b1, 5'd31, IDLE};
        do_reset();
        for (int i = 0; i < 8; i++) begin
            logic [25:0] v;
            v = vec[i];
            {ex_load, ex_wen, ex_rd, id_use_rs1, id_rs1, id_use_rs2, id_rs2} = v[25:7];
            #1;
            tests++;
            if (obs8 !== v[6:0]) begin
                fails++;
                $display("FAIL load_use v%0d: got %b want %b", i, obs8, v[6:0]);
            end
            tick();
        end
        clear_inputs();
    endtask

    task automatic test_branch();
        do_reset();
        ex_branch_taken = 1'b1;
        ex_load = 1'b1; ex_wen = 1'b1; ex_rd = 5'd9; id_use_rs1 = 1'b1; id_rs1 = 5'd9;
        #1;
        tests++;
        if (obs8 !== BR) begin
            fails++;
            $display("FAIL branch_vs_loaduse: got %b want %b", obs8, BR);
        end
        tick();
        ex_load = 1'b0;
        #1;
        tests++;
        if (obs8 !== BR) begin
            fails++;
            $display("FAIL branch_alone: got %b want %b", obs8, BR);
        end
`ifdef PIPE_CTRL_PERF_CNT_EN
        tests++;
        if (pfl8 !== 64'd1 || pst8 !== 64'd0) begin
            fails++;
            $display("FAIL branch_perf: got flush %0d stall %0d want 1/0", pfl8, pst8);
        end
`endif
        tick();
        clear_inputs();
        #1;
        tests++;
        if (obs8 !== IDLE) begin
            fails++;
            $display("FAIL branch_after: got %b want %b", obs8, IDLE);
        end
    endtask

    task automatic test_reset_mid_wait();
        do_reset();
        ex_md_op = 1'b1;
        for (int c = 0; c < 4; c++) tick();
        #1;
        tests++;
        if (obs8 !== WAIT) begin
            fails++;
            $display("FAIL midwait_pre: got %b want %b", obs8, WAIT);
        end
        reset = 1'b1;
        #1;
        tests++;
        if (obs8 !== IDLE) begin
            fails++;
            $display("FAIL midwait_in_reset: got %b want %b", obs8, IDLE);
        end
        tick();
        reset = 1'b0;
        ex_md_op = 1'b0;
        #1;
        tests++;
        if (obs8 !== IDLE) begin
            fails++;
            $display("FAIL midwait_after: got %b want %b", obs8, IDLE);
        end
        tick();
        #1;
        tests++;
        if (obs8 !== IDLE) begin
            fails++;
            $display("FAIL midwait_residual: got %b want %b", obs8, IDLE);
        end
        ex_md_op = 1'b1;
        #1;
        tests++;
        if (obs8 !== ENTRY) begin
            fails++;
            $display("FAIL midwait_reentry: got %b want %b", obs8, ENTRY);
        end
        tick();
        clear_inputs();
    endtask

    initial begin
        clear_inputs();
        reset = 1'b1;
        tick();
        test_reset();
        test_load_use();
        test_md_single();
        test_back_to_back();
        test_branch();
        test_reset_mid_wait();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/pipe_ctrl.md
Name: pipe_ctrl

Overview:
- Central hazard and sequencing controller for the 5-stage rv64IM pipeline.
- Drives the stall and flush controls of the IF/ID and ID/EX pipeline registers, and holds the PC.
- Injects bubbles into EX/MEM while a multi-cycle M-extension op (div/rem) occupies EX.
- Resolves three hazards with a fixed priority: multi-cycle EX op, then taken branch/jump, then load-use.

Parameters:
- MD_LATENCY, 8, total cycles a div/rem occupies EX (legal range 1..64; 1 means never stall).
- CNT_W, 6, width of the internal latency down-counter (must hold MD_LATENCY-2).

Ports:
- clock  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- id_rs1  in  5  rs1 index of the instruction in ID.
- id_rs2  in  5  rs2 index of the instruction in ID.
- id_use_rs1  in  1  ID instruction reads rs1.
- id_use_rs2  in  1  ID instruction reads rs2.
- ex_load  in  1  EX instruction is a load.
- ex_wen  in  1  EX instruction writes the regfile.
- ex_rd  in  5  EX destination register.
- ex_md_op  in  1  EX holds a multi-cycle div/rem op.
- ex_branch_taken  in  1  EX resolved a taken branch/jump; IF redirects the PC itself.
- stall_pc  out  1  hold the PC.
- stall_if_id  out  1  stall the IF/ID register.
- flush_if_id  out  1  load NOP into IF/ID.
- stall_id_ex  out  1  stall the ID/EX register.
- flush_id_ex  out  1  clear ID/EX (bubble).
- ex_bubble  out  1  force wen/load/store/exit to 0 on the EX/MEM register inputs.
- md_busy  out  1  multi-cycle op in progress (state MD_WAIT).

Behaviour:
- State machine has two states, RUN and MD_WAIT; an internal counter cnt has width CNT_W.
- Reset (synchronous, active-high): state<=RUN, cnt<=0. While reset is high, every output is 0.
- Outputs are combinational from state, cnt and the inputs. The only registered elements are state, cnt and the optional counters.
- Multi-cycle op, entry:
  - Condition: state RUN, ex_md_op=1, MD_LATENCY>1.
  - Assert stall_pc, stall_if_id, stall_id_ex and ex_bubble.
  - Next cycle: cnt<=MD_LATENCY-2, state<=MD_WAIT.
- Multi-cycle op, MD_WAIT with cnt!=0:
  - Assert the same four stalls plus md_busy.
  - cnt<=cnt-1.
- Multi-cycle op, MD_WAIT with cnt==0:
  - Release cycle: md_busy=1, all other outputs 0.
  - The result flows into EX/MEM this cycle; state<=RUN.
- Multi-cycle timing:
  - The op occupies EX for exactly MD_LATENCY cycles, MD_LATENCY-1 of them stalled.
  - Back-to-back div ops each take the full MD_LATENCY cycles, with no idle cycle between them.
- MD_LATENCY=1: ex_md_op is ignored and the FSM never leaves RUN.
- While a multi-cycle stall is active (entry cycle or MD_WAIT), ex_branch_taken and the load-use check are ignored; this stall wins.
- Taken branch (RUN, no multi-cycle stall):
  - flush_if_id=1, flush_id_ex=1; all stalls 0.
  - The branch itself proceeds to MEM.
- Load-use hazard:
  - Condition: ex_load & ex_wen & (ex_rd!=0) & ((id_use_rs1 & id_rs1==ex_rd) | (id_use_rs2 & id_rs2==ex_rd)).
  - Response: stall_pc=1, stall_if_id=1, flush_id_ex=1, for exactly 1 cycle.
  - The next cycle EX holds the bubble, so the hazard clears.
- If a taken branch and a load-use hazard occur in the same cycle, branch wins: flush only, no stall.
- Invariants: stall_X and flush_X are never both 1 for the same register, and ex_bubble=1 implies stall_id_ex=1.
- Reset mid-MD_WAIT: controller returns to RUN, cnt=0; the partial op is discarded because the pipeline registers also reset.

Optional Feature:
- Macro: PIPE_CTRL_PERF_CNT_EN.
- Defined:
  - Adds outputs perf_stall_cycles (64 bit), counting cycles with stall_pc=1.
  - Adds perf_flush_cycles (64 bit), counting cycles with flush_if_id=1.
  - Adds perf_md_ops (64 bit), incremented on each entry into MD_WAIT.
  - All three reset to 0, are not cleared otherwise, and wrap modulo 2^64.
- Undefined: these ports and their counters do not exist; all other behaviour is identical.

Test Plan:
- Reset held 3 cycles with ex_md_op=1 and ex_branch_taken=1 -> all outputs 0 throughout; state RUN after release.
- ex_load=1, ex_wen=1, ex_rd=5, id_use_rs2=1, id_rs2=5 -> exactly 1 cycle of stall_pc=stall_if_id=flush_id_ex=1. The same stimulus with ex_rd=0 -> no stall.
- MD_LATENCY=8, single div enters EX at cycle t:
  - cycles t..t+6: stall_pc=stall_id_ex=ex_bubble=1.
  - cycle t+7: release.
  - md_busy=1 for cycles t+1..t+7.
- Two back-to-back divs, MD_LATENCY=4 -> the second div's stall begins at t+4; 6 stall cycles in total.
- ex_branch_taken=1 together with a load-use match -> flush_if_id=flush_id_ex=1, stall_pc=0. With PIPE_CTRL_PERF_CNT_EN defined, perf_flush_cycles increments by 1.
- Reset asserted at cnt=3 in MD_WAIT -> next cycle state RUN, md_busy=0, no residual stall.
